// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory responder with configurable wait-states
module dmem_responder #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        load_done,
   output logic        store_done,
   output logic        busy,
   output logic        addr_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t                 state;
   logic [3:0]             cnt;
   logic                   is_store;
   logic [ADDR_BITS-1:0]   idx_q;
   logic                   oor_q;
   logic [31:0]            wdata_q;
   logic [31:0]            mem [0:(1<<ADDR_BITS)-1];
   logic [31:0]            addr_hi;
   logic                   in_range;
   logic                   mem_we;

   assign addr_hi  = addr >> (ADDR_BITS + 2);
   assign in_range = (addr_hi == 32'd0);
   assign mem_we   = rstn && (state == S_RESP) && is_store && !oor_q;

   // RAM survives reset; a reset on the completing edge suppresses the write
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_q] <= wdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         rdata      <= '0;
         load_done  <= 1'b0;
         store_done <= 1'b0;
         busy       <= 1'b0;
         addr_err   <= 1'b0;
         is_store   <= 1'b0;
         idx_q      <= '0;
         oor_q      <= 1'b0;
         wdata_q    <= '0;
      end else begin
         load_done  <= 1'b0;
         store_done <= 1'b0;
         addr_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               // busy still high here means this is the done cycle: drop requests
               if (busy) begin
                  busy <= 1'b0;
               end else if (req_load || req_store) begin
                  busy     <= 1'b1;
                  is_store <= req_store;
                  idx_q    <= addr[ADDR_BITS+1:2];
                  oor_q    <= !in_range;
                  wdata_q  <= wdata;
                  if (WAIT_CYCLES > 0) begin
                     state <= S_WAIT;
                     cnt   <= WAIT_INIT;
                  end else begin
                     state <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            S_RESP: begin
               state    <= S_IDLE;
               addr_err <= oor_q;
               if (is_store) begin
                  store_done <= 1'b1;
               end else begin
                  load_done <= 1'b1;
                  rdata     <= oor_q ? 32'd0 : mem[idx_q];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
